// File: rtl/ps2_key2state.sv
// PS/2 set-2 keyboard receiver with key decoder producing a held-key movement state.
// Optional build macro PARITY_CHECK_EN: drop frames whose odd parity check fails.
module ps2_key2state #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [3:0] move_state,
  output logic [7:0] out,
  output logic       done
);
  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    c_sync, d_sync;
  logic          sc, sd, fc, fall;
  logic [FW-1:0] filt_cnt;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    sh;
  logic          par_ok, frame_ok, ext, brk;
  logic [3:0]    km;

  assign sc = c_sync[1];
  assign sd = d_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  // Filtered clock only follows the synchronised line after FILTER_LEN differing cycles.
  assign fall = fc && !sc && (filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fc       <= 1'b1;
      filt_cnt <= '0;
    end else if (sc == fc) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      fc       <= sc;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      idle_cnt <= '0;
      sh       <= '0;
    end else begin
      if (fall || bit_cnt == 4'd0) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + 1'b1;
      if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (!sd) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          sh      <= {sd, sh[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= '0;
        end
      end else if (bit_cnt != 4'd0 && idle_cnt == TW'(TIMEOUT_CYC)) begin
        bit_cnt <= '0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic par;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      par <= 1'b0;
    else if (fall && bit_cnt == 4'd9) par <= sd;
  end
  assign par_ok = ^{sh, par};
`else
  assign par_ok = 1'b1;
`endif

  assign frame_ok = fall && (bit_cnt == 4'd10) && sd && par_ok;

  // {jump key, dir code}; zero means the code drives nothing.
  function automatic logic [3:0] keymap(input logic [7:0] b, input logic e);
    case ({e, b})
      9'h01D, 9'h175: keymap = 4'b0001;
      9'h01C, 9'h16B: keymap = 4'b0010;
      9'h023, 9'h174: keymap = 4'b0011;
      9'h01B, 9'h172: keymap = 4'b0100;
      9'h029:         keymap = 4'b1000;
      default:        keymap = 4'b0000;
    endcase
  endfunction

  assign km = keymap(sh, ext);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out        <= '0;
      done       <= 1'b0;
      move_state <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      done <= frame_ok;
      if (frame_ok) begin
        out <= sh;
        if (sh == 8'hE0) begin
          ext <= 1'b1;
        end else if (sh == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (km[3]) begin
            move_state[3] <= ~brk;
          end else if (km[2:0] != 3'b000) begin
            // Releasing a key other than the current direction leaves dir alone.
            if (!brk)                             move_state[2:0] <= km[2:0];
            else if (move_state[2:0] == km[2:0]) move_state[2:0] <= 3'b000;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key2state.sv
// Directed bench for ps2_key2state: a byte-level keyboard model is checked against the DUT every cycle.
module tb_ps2_key2state;
  logic       clk = 1'b0;
  logic       rst, ps2c, ps2d;
  logic [3:0] move_state;
  logic [7:0] out;
  logic       done;

  ps2_key2state #(.FILTER_LEN(8), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
    .move_state(move_state), .out(out), .done(done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0, n_done = 0, d0;
  logic [7:0] exp_q[$];
  logic [7:0] m_out;
  logic [2:0] m_dir;
  logic       m_jump, m_ext, m_brk;
  int         dirmap[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_out = 8'h00; m_dir = 3'd0; m_jump = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    exp_q.delete();
  endtask

  // Keyboard semantics: prefixes latch, any other byte resolves the key and clears them.
  task automatic model_apply(input logic [7:0] b);
    int key;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      key = {23'd0, m_ext, b};
      if (key == 'h029) m_jump = !m_brk;
      else if (dirmap.exists(key)) begin
        if (!m_brk) m_dir = 3'(dirmap[key]);
        else if (m_dir == 3'(dirmap[key])) m_dir = 3'd0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // One clock of the bench: sample on the falling edge and compare against the model.
  task automatic tick();
    logic [7:0] b;
    @(negedge clk);
    if (!rst) begin
      model_clear();
      check("done_in_reset", {31'd0, done}, 32'd0);
    end else if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
      else begin
        b = exp_q.pop_front();
        n_done++;
        m_out = b;
        model_apply(b);
      end
    end
    check("out", {24'd0, out}, {24'd0, m_out});
    check("move_state", {28'd0, move_state}, {28'd0, m_jump, m_dir});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop = 1'b1,
                            input logic badpar = 1'b0, input int nbits = 11);
    logic [10:0] f;
    logic        acc;
    f   = {stop, (~^b) ^ badpar, b, 1'b0};
    acc = (nbits == 11) && stop;
`ifdef PARITY_CHECK_EN
    if (badpar) acc = 1'b0;
`endif
    if (acc) exp_q.push_back(b);
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      repeat (8) tick();
      ps2c = 1'b0;
      repeat (16) tick();
      ps2c = 1'b1;
      repeat (8) tick();
    end
    ps2d = 1'b1;
    if (nbits == 11) begin
      repeat (20) tick();
      check("frame_consumed", exp_q.size(), 32'd0);
    end
  endtask

  task automatic send_seq(input logic [7:0] a, input logic [7:0] b = 8'h00,
                          input logic [7:0] c = 8'h00, input int n = 1);
    send_frame(a);
    if (n > 1) send_frame(b);
    if (n > 2) send_frame(c);
  endtask

  initial begin
    dirmap['h01D] = 1; dirmap['h175] = 1;
    dirmap['h01C] = 2; dirmap['h16B] = 2;
    dirmap['h023] = 3; dirmap['h174] = 3;
    dirmap['h01B] = 4; dirmap['h172] = 4;
    model_clear();
    rst = 1'b0; ps2c = 1'b1; ps2d = 1'b1;
    #1;
    check("rst_out", {24'd0, out}, 32'h00);
    check("rst_state", {28'd0, move_state}, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (4) tick();
    rst = 1'b1;
    repeat (4) tick();

    // press/release up
    d0 = n_done;
    send_seq(8'h1D);
    check("t1_out", {24'd0, out}, 32'h1D);
    check("t1_up", {28'd0, move_state}, 32'h1);
    send_seq(8'hF0, 8'h1D, 8'h00, 2);
    check("t1_stop", {28'd0, move_state}, 32'h0);
    check("t1_dones", n_done - d0, 32'd3);

    // extended keys, last-pressed wins, foreign break ignored
    send_seq(8'hE0, 8'h74, 8'h00, 2);
    check("t2_right", {28'd0, move_state}, 32'h3);
    send_seq(8'h1C);
    check("t2_left", {28'd0, move_state}, 32'h2);
    send_seq(8'hF0, 8'h23, 8'h00, 2);
    check("t2_keep", {28'd0, move_state}, 32'h2);
    send_seq(8'hE0, 8'hF0, 8'h6B, 3);
    check("t2_rel", {28'd0, move_state}, 32'h0);

    // jump independent of direction
    send_seq(8'h1B, 8'h29, 8'h00, 2);
    check("t3_down_jump", {28'd0, move_state}, 32'hC);
    send_seq(8'hF0, 8'h29, 8'h00, 2);
    check("t3_jump_rel", {28'd0, move_state}, 32'h4);
    send_seq(8'hF0, 8'h1B, 8'h00, 2);
    check("t3_stop", {28'd0, move_state}, 32'h0);

    // unmapped code clears the ext prefix so a later 72 is plain (unmapped)
    send_seq(8'hE0, 8'h15, 8'h72, 3);
    check("t3_unmapped", {28'd0, move_state}, 32'h0);

    // bad stop bit
    d0 = n_done;
    send_frame(8'h1D, 1'b0);
    check("t4_nodone", n_done - d0, 32'd0);
    check("t4_out", {24'd0, out}, 32'h72);
    check("t4_state", {28'd0, move_state}, 32'h0);

    // bad parity
    d0 = n_done;
    send_frame(8'h1D, 1'b1, 1'b1);
`ifdef PARITY_CHECK_EN
    check("t5_nodone", n_done - d0, 32'd0);
    check("t5_state", {28'd0, move_state}, 32'h0);
`else
    check("t5_done", n_done - d0, 32'd1);
    check("t5_out", {24'd0, out}, 32'h1D);
    check("t5_state", {28'd0, move_state}, 32'h1);
`endif

    // partial frame, idle timeout, then a clean frame
    send_frame(8'h5A, 1'b1, 1'b0, 6);
    repeat (300) tick();
    send_frame(8'h1C);
    check("t6_out", {24'd0, out}, 32'h1C);
    check("t6_state", {28'd0, move_state}, 32'h2);

    // reset mid-frame clears outputs at once, next frame resyncs
    send_frame(8'h1D, 1'b1, 1'b0, 5);
    rst = 1'b0;
    #1;
    check("t6_rst_out", {24'd0, out}, 32'h00);
    check("t6_rst_state", {28'd0, move_state}, 32'h0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    repeat (4) tick();
    rst = 1'b1;
    repeat (4) tick();
    send_frame(8'h1D);
    check("t6_resync_out", {24'd0, out}, 32'h1D);
    check("t6_resync_state", {28'd0, move_state}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
